// File: rtl/bcd_conv_scheduler_if.sv
// Bundle of every signal between the three-channel BCD conversion
// scheduler, its requesting clients and the shared serial converter.
// master : client/converter side (drives req, operands, converter reply)
// slave  : scheduler side
interface bcd_conv_scheduler_if #(
    parameter int BIN_W = 14,
    parameter int BCD_W = 16
);
    logic [2:0]       req;
    logic [BIN_W-1:0] bin0;
    logic [BIN_W-1:0] bin1;
    logic [BIN_W-1:0] bin2;
    logic [2:0]       ack;
    logic [BCD_W-1:0] bcd0;
    logic [BCD_W-1:0] bcd1;
    logic [BCD_W-1:0] bcd2;
    logic             conv_start;
    logic [BIN_W-1:0] conv_bin;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             busy;
    logic             err;

    modport master (
        output req, bin0, bin1, bin2, conv_done, conv_bcd,
        input  ack, bcd0, bcd1, bcd2, conv_start, conv_bin, busy, err
    );

    modport slave (
        input  req, bin0, bin1, bin2, conv_done, conv_bcd,
        output ack, bcd0, bcd1, bcd2, conv_start, conv_bin, busy, err
    );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter
// between three request channels. Each grant walks IDLE -> ISSUE ->
// WAIT -> STORE; the result lands in the granted channel's BCD
// register with a one-cycle ack.
// Optional macro BCD_SCHED_TIMEOUT_EN: aborts a WAIT that lasts
// TIMEOUT_CYC cycles without conv_done and pulses err instead of ack.
module bcd_conv_scheduler #(
    parameter int BIN_W       = 14,
    parameter int BCD_W       = 16,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_conv_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       grant_reg;
    logic [1:0]       last_grant_reg;
    logic [BIN_W-1:0] conv_bin_reg;
    logic [BCD_W-1:0] result_reg;

    logic [BIN_W-1:0] bin_sel  [3];
    logic [BCD_W-1:0] bcd_out  [3];
    logic [1:0]       cand     [3];
    logic [2:0]       cand_hit;
    logic [2:0]       ack_vec;
    logic [1:0]       rr_first;
    logic [1:0]       grant_pick;
    logic             grant_found;
    logic             timeout_hit;

    // A zero timeout would abort every conversion before it could finish
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    assign bin_sel[0] = bus.bin0;
    assign bin_sel[1] = bus.bin1;
    assign bin_sel[2] = bus.bin2;

    // Search begins one channel past the last one served, wrapping 2 -> 0
    assign rr_first = (last_grant_reg == 2'd2) ? 2'd0 : last_grant_reg + 2'd1;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_cand
        logic [2:0] sum;
        assign sum          = {1'b0, rr_first} + 3'(gi);
        assign cand[gi]     = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        assign cand_hit[gi] = bus.req[cand[gi]];
    end

    // First requesting channel in rotated order wins
    always_comb begin
        grant_found = |cand_hit;
        grant_pick  = cand[2];
        if (cand_hit[0]) begin
            grant_pick = cand[0];
        end else if (cand_hit[1]) begin
            grant_pick = cand[1];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; conv_done only matters while waiting
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.conv_done) begin
                    state_next = STORE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            STORE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant capture, operand hold, result capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg      <= 2'd0;
            last_grant_reg <= 2'd2;
            conv_bin_reg   <= '0;
            result_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        grant_reg    <= grant_pick;
                        conv_bin_reg <= bin_sel[grant_pick];
                    end
                end
                WAIT: begin
                    if (bus.conv_done) begin
                        result_reg <= bus.conv_bcd;
                    end else if (timeout_hit) begin
                        last_grant_reg <= grant_reg;
                    end
                end
                STORE: begin
                    last_grant_reg <= grant_reg;
                end
                default: begin
                end
            endcase
        end
    end

    // Per-channel held result; the new value is shown during STORE itself
    for (gi = 0; gi < 3; gi++) begin : g_chan
        logic [BCD_W-1:0] bcd_reg;
        logic             store_hit;

        assign store_hit = (state_reg == STORE) && (grant_reg == 2'(gi));

        // Only the granted channel's register moves
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bcd_reg <= '0;
            end else if (store_hit) begin
                bcd_reg <= result_reg;
            end
        end

        assign bcd_out[gi] = store_hit ? result_reg : bcd_reg;
        assign ack_vec[gi] = store_hit;
    end

`ifdef BCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_reg;

    // Last WAIT cycle allowed; err follows one cycle later while in IDLE
    assign timeout_hit = (state_reg == WAIT) && !bus.conv_done &&
                         (wait_cnt_reg == CNT_LAST);

    // WAIT cycle counter, cleared while entering WAIT from ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= timeout_hit;
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    assign bus.ack        = ack_vec;
    assign bus.bcd0       = bcd_out[0];
    assign bus.bcd1       = bcd_out[1];
    assign bus.bcd2       = bcd_out[2];
    assign bus.conv_start = (state_reg == ISSUE);
    assign bus.conv_bin   = conv_bin_reg;
    assign bus.busy       = (state_reg != IDLE);

endmodule

// File: doc/bcd_conv_scheduler.md
BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  BIN_W  14  binary operand width
  BCD_W  16  BCD result width (4 digits)
  TIMEOUT_CYC  31  max WAIT cycles before abort (used only with BCD_SCHED_TIMEOUT_EN)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req  in  3  per-channel conversion request, level, held until ack
  bin0, bin1, bin2  in  BIN_W  per-channel binary operand
  ack  out  3  one-cycle pulse: channel result register updated
  bcd0, bcd1, bcd2  out  BCD_W  per-channel held BCD result
  conv_start  out  1  one-cycle start pulse to the shared serial converter
  conv_bin  out  BIN_W  operand to the converter
  conv_done  in  1  one-cycle pulse from the converter: conv_bcd valid
  conv_bcd  in  BCD_W  converter result
  busy  out  1  high in every state except IDLE
  err  out  1  one-cycle timeout pulse

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, STORE.
REQ-004 IDLE: if any req bit is high, the block SHALL grant one channel by round-robin, searching from (last_grant+1) mod 3 upward.
REQ-005 On grant, the block SHALL register the channel index and its bin into conv_bin, then go to ISSUE.
REQ-006 ISSUE SHALL last exactly one cycle with conv_start=1, then go to WAIT.
REQ-007 conv_bin SHALL stay stable from ISSUE until the exit from WAIT.
REQ-008 WAIT: when conv_done=1, the block SHALL capture conv_bcd internally and go to STORE.
REQ-009 conv_done SHALL be ignored in IDLE, ISSUE and STORE.
REQ-010 STORE SHALL last one cycle: it drives bcdK (K = granted channel), pulses ack[K], sets last_grant=K, then returns to IDLE.
REQ-011 Other bcd registers SHALL be unchanged in STORE.
REQ-012 Minimum turnaround SHALL be 1 + 1 + converter latency + 1 cycles per conversion. Back-to-back grants SHALL be possible (STORE→IDLE→ISSUE).
REQ-013 If req[K] deasserts mid-conversion, the conversion SHALL still complete and ack[K] SHALL still pulse.
REQ-014 A change in binK after grant SHALL NOT affect the in-flight conversion.
REQ-015 At most one ack bit SHALL be high in any cycle. ack and err SHALL never be high together.
REQ-016 With all three req bits held high, the grant order SHALL be 0,1,2,0,... with no starvation.
REQ-017 The operand SHALL pass unmodified. Range checking is the converter's responsibility.

Reset
REQ-018 rst_n low SHALL immediately force:
  - state=IDLE, last_grant=2 (first search starts at channel 0)
  - conv_start=0, conv_bin=0, ack=0, err=0, busy=0
  - bcd0/1/2=0, timeout counter=0
REQ-019 Reset mid-conversion SHALL abandon the operation. A conv_done arriving after reset release SHALL be ignored, since the FSM is in IDLE.
REQ-020 Deassertion of rst_n SHALL be synchronised externally. The block SHALL act on req from the first rising edge after release.

Configuration
REQ-021 Macro BCD_SCHED_TIMEOUT_EN defined: a counter SHALL increment each WAIT cycle.
REQ-022 With the macro defined, reaching TIMEOUT_CYC without conv_done SHALL:
  - pulse err for one cycle
  - leave bcdK unchanged and not assert ack
  - set last_grant=K and return to IDLE
REQ-023 The counter SHALL clear on entry to WAIT.
REQ-024 Macro undefined: WAIT SHALL persist until conv_done, err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Reset, then req=3'b001, bin0=14'd1234, converter returns 16'h1234 after 15 cycles -> one conv_start pulse with conv_bin=1234; bcd0=16'h1234 and ack=3'b001 in the same single cycle.
  - req=3'b111 held, bin0/1/2 = 9999/42/0 -> grant order 0,1,2,0; bcd0=16'h9999, bcd1=16'h0042, bcd2=16'h0000.
  - req=3'b010, bin1 changed 5000→7 one cycle after conv_start -> conv_bin stays 5000; bcd1=16'h5000.
  - rst_n pulled low during WAIT for channel 2, conv_done pulsed 3 cycles after release -> no ack, bcd2=0, busy=0.
  - Macro defined, converter never asserts conv_done -> err pulses exactly TIMEOUT_CYC cycles after WAIT entry; no ack; next req served.
  - Macro undefined, same stimulus -> busy stays 1, err stays 0.
